ptw_sv39: RTL and testbench

PTW_SV39 -- requirements
Module: ptw_sv39

---
 rtl/ptw_pkg.sv | 22 ++
 rtl/pte_check.sv | 42 ++++
 rtl/ptw_sv39.sv | 130 +++++++++++++
 tb/tb_ptw_sv39.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ptw_pkg.sv
// Shared types and constants for the Sv39 page-table walker.
package ptw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } ptw_state_e;

  localparam logic [3:0]  SATP_MODE_SV39 = 4'd8;
  localparam int unsigned PAGE_SHIFT     = 12;

  localparam int unsigned PTE_V = 0;
  localparam int unsigned PTE_R = 1;
  localparam int unsigned PTE_W = 2;
  localparam int unsigned PTE_X = 3;

  localparam int unsigned PPN_MSB = 53;
  localparam int unsigned PPN_LSB = 10;

endpackage

// File: rtl/pte_check.sv
// Combinational PTE decode: leaf detection, fault detection and leaf PA composition.
module pte_check
  import ptw_pkg::*;
(
  input  logic [63:0] pte,
  input  logic [1:0]  level,
  input  logic [29:0] va_low,
  output logic        is_leaf,
  output logic        fault,
  output logic [63:0] leaf_pa
);

  logic [43:0] ppn;
  logic        misaligned;
  logic        unused_pte;

  assign ppn        = pte[PPN_MSB:PPN_LSB];
  assign unused_pte = ^{pte[63:54], pte[9:4]};

  always_comb begin
    is_leaf    = pte[PTE_R] | pte[PTE_X];
    misaligned = 1'b0;
    case (level)
      2'd1:    misaligned = (ppn[8:0] != '0);
      2'd2:    misaligned = (ppn[17:0] != '0);
      default: misaligned = 1'b0;
    endcase

    // A pointer PTE at the last level has nowhere left to go.
    fault = !pte[PTE_V]
          | (!pte[PTE_R] & pte[PTE_W])
          | (is_leaf & misaligned)
          | (!is_leaf & (level == 2'd0));

    case (level)
      2'd0:    leaf_pa = {8'h00, ppn, va_low[11:0]};
      2'd1:    leaf_pa = {8'h00, ppn[43:9], va_low[20:0]};
      default: leaf_pa = {8'h00, ppn[43:18], va_low[29:0]};
    endcase
  end

endmodule

// File: rtl/ptw_sv39.sv
// Sv39 three-level page-table walker responding on the mmu_valid/mmu_finish handshake.
module ptw_sv39
  import ptw_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mmu_valid,
  input  logic [63:0] va,
  input  logic [63:0] satp,
  output logic        mmu_finish,
  output logic [63:0] pa,
  output logic        page_fault,
  output logic        preq_valid,
  output logic [63:0] preq_addr,
  input  logic        presp_data_ok,
  input  logic [63:0] presp_data
);

  ptw_state_e  state_q, state_d;
  logic [38:0] va_q, va_d;
  logic [63:0] base_q, base_d;
  logic [1:0]  level_q, level_d;
  logic [63:0] pte_q, pte_d;
  logic [63:0] pa_q, pa_d;
  logic        fault_q, fault_d;

  logic        is_leaf;
  logic        pte_fault;
  logic [63:0] leaf_pa;
  logic [8:0]  vpn;
  logic        unused_satp;

  assign unused_satp = ^satp[59:44];

  pte_check u_pte_check (
    .pte     (pte_q),
    .level   (level_q),
    .va_low  (va_q[29:0]),
    .is_leaf (is_leaf),
    .fault   (pte_fault),
    .leaf_pa (leaf_pa)
  );

  always_comb begin
    case (level_q)
      2'd2:    vpn = va_q[38:30];
      2'd1:    vpn = va_q[29:21];
      default: vpn = va_q[20:12];
    endcase
  end

  // Address derives only from registers, so it stays stable for the whole REQ wait.
  assign preq_addr  = base_q + {52'd0, vpn, 3'b000};
  assign preq_valid = (state_q == REQ);
  assign mmu_finish = (state_q == DONE);
  assign pa         = pa_q;
  assign page_fault = fault_q;

  always_comb begin
    state_d = state_q;
    va_d    = va_q;
    base_d  = base_q;
    level_d = level_q;
    pte_d   = pte_q;
    pa_d    = pa_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (mmu_valid) begin
          if (satp[63:60] == SATP_MODE_SV39) begin
            va_d    = va[38:0];
            base_d  = {20'd0, satp[43:0]} << PAGE_SHIFT;
            level_d = 2'd2;
            state_d = REQ;
          end else begin
            pa_d    = va;
            fault_d = 1'b0;
            state_d = DONE;
          end
        end
      end
      REQ: begin
        if (presp_data_ok) begin
          pte_d   = presp_data;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (pte_fault) begin
          pa_d    = '0;
          fault_d = 1'b1;
          state_d = DONE;
        end else if (is_leaf) begin
          pa_d    = leaf_pa;
          fault_d = 1'b0;
          state_d = DONE;
        end else begin
          base_d  = {20'd0, pte_q[PPN_MSB:PPN_LSB]} << PAGE_SHIFT;
          level_d = level_q - 2'd1;
          state_d = REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      va_q    <= '0;
      base_q  <= '0;
      level_q <= '0;
      pte_q   <= '0;
      pa_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      va_q    <= va_d;
      base_q  <= base_d;
      level_q <= level_d;
      pte_q   <= pte_d;
      pa_q    <= pa_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_ptw_sv39.sv
// Directed self-checking bench for ptw_sv39 with a 2-cycle-latency PTE responder.
module tb_ptw_sv39;

  logic        clk = 1'b0;
  logic        rst;
  logic        mmu_valid;
  logic [63:0] va;
  logic [63:0] satp;
  logic        mmu_finish;
  logic [63:0] pa;
  logic        page_fault;
  logic        preq_valid;
  logic [63:0] preq_addr;
  logic        presp_data_ok;
  logic [63:0] presp_data;

  int unsigned total = 0;
  int unsigned bad   = 0;

  localparam logic [63:0] SATP_SV39 = 64'h8000_0000_0008_0000;
  localparam logic [63:0] VA_WALK   = 64'h0000_0000_4000_1234;

  always #5 clk = ~clk;

  ptw_sv39 dut (
    .clk           (clk),
    .rst           (rst),
    .mmu_valid     (mmu_valid),
    .va            (va),
    .satp          (satp),
    .mmu_finish    (mmu_finish),
    .pa            (pa),
    .page_fault    (page_fault),
    .preq_valid    (preq_valid),
    .preq_addr     (preq_addr),
    .presp_data_ok (presp_data_ok),
    .presp_data    (presp_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%016h exp=0x%016h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [63:0] v, input logic [63:0] s);
    va        = v;
    satp      = s;
    mmu_valid = 1'b1;
    tick();
    mmu_valid = 1'b0;
  endtask

  // Wait (bounded) for a request, check its address, answer two cycles later.
  task automatic serve(input string tag, input logic [63:0] exp_addr, input logic [63:0] data);
    int unsigned n = 0;
    while (!preq_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, {63'd0, preq_valid}, 64'd1);
    chk({tag, "_addr"}, preq_addr, exp_addr);
    tick();
    tick();
    chk({tag, "_addr_hold"}, preq_addr, exp_addr);
    presp_data    = data;
    presp_data_ok = 1'b1;
    tick();
    presp_data_ok = 1'b0;
    presp_data    = '0;
    chk({tag, "_req_drop"}, {63'd0, preq_valid}, 64'd0);
  endtask

  task automatic wait_finish(input string tag);
    int unsigned n = 0;
    while (!mmu_finish && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_finish"}, {63'd0, mmu_finish}, 64'd1);
  endtask

  initial begin
    rst           = 1'b1;
    mmu_valid     = 1'b0;
    va            = '0;
    satp          = '0;
    presp_data_ok = 1'b0;
    presp_data    = '0;
    tick();
    tick();
    chk("rst_finish", {63'd0, mmu_finish}, 64'd0);
    chk("rst_preq", {63'd0, preq_valid}, 64'd0);
    chk("rst_fault", {63'd0, page_fault}, 64'd0);
    chk("rst_pa", pa, 64'd0);
    chk("rst_addr", preq_addr, 64'd0);
    rst = 1'b0;
    tick();

    // Bare mode: finish on the cycle after mmu_valid, no bus traffic.
    start(64'h1234, 64'd0);
    chk("bare_finish", {63'd0, mmu_finish}, 64'd1);
    chk("bare_pa", pa, 64'h1234);
    chk("bare_fault", {63'd0, page_fault}, 64'd0);
    chk("bare_preq", {63'd0, preq_valid}, 64'd0);
    tick();
    chk("bare_finish_pulse", {63'd0, mmu_finish}, 64'd0);
    tick();

    // Full 4 KiB walk.
    start(VA_WALK, SATP_SV39);
    serve("w4k_l2", 64'h8000_0008, 64'h2000_0401);
    serve("w4k_l1", 64'h8000_1000, 64'h2000_0801);
    serve("w4k_l0", 64'h8000_2008, 64'h2400_000F);
    wait_finish("w4k");
    chk("w4k_pa", pa, 64'h9000_0234);
    chk("w4k_fault", {63'd0, page_fault}, 64'd0);
    tick();
    chk("w4k_finish_pulse", {63'd0, mmu_finish}, 64'd0);
    tick();
    tick();
    chk("w4k_pa_hold", pa, 64'h9000_0234);

    // Gigapage leaf at level 2.
    start(VA_WALK, SATP_SV39);
    serve("giga", 64'h8000_0008, 64'h2000_000F);
    wait_finish("giga");
    chk("giga_pa", pa, 64'h8000_1234);
    chk("giga_fault", {63'd0, page_fault}, 64'd0);
    tick();
    tick();

    // Invalid L2 PTE.
    start(VA_WALK, SATP_SV39);
    serve("inv", 64'h8000_0008, 64'h0);
    wait_finish("inv");
    chk("inv_fault", {63'd0, page_fault}, 64'd1);
    chk("inv_preq", {63'd0, preq_valid}, 64'd0);
    tick();
    tick();
    chk("inv_fault_hold", {63'd0, page_fault}, 64'd1);

    // Misaligned gigapage.
    start(VA_WALK, SATP_SV39);
    serve("mis", 64'h8000_0008, 64'h2000_040F);
    wait_finish("mis");
    chk("mis_fault", {63'd0, page_fault}, 64'd1);
    tick();
    tick();

    // Pointer PTE at level 0.
    start(VA_WALK, SATP_SV39);
    serve("nl0_l2", 64'h8000_0008, 64'h2000_0401);
    serve("nl0_l1", 64'h8000_1000, 64'h2000_0801);
    serve("nl0_l0", 64'h8000_2008, 64'h2000_0C01);
    wait_finish("nl0");
    chk("nl0_fault", {63'd0, page_fault}, 64'd1);
    tick();
    tick();

    // Reset with a read outstanding, then a late response.
    start(VA_WALK, SATP_SV39);
    chk("rr_req", {63'd0, preq_valid}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_preq", {63'd0, preq_valid}, 64'd0);
    chk("rr_fault", {63'd0, page_fault}, 64'd0);
    chk("rr_pa", pa, 64'd0);
    presp_data    = 64'h2000_000F;
    presp_data_ok = 1'b1;
    tick();
    presp_data_ok = 1'b0;
    presp_data    = '0;
    tick();
    tick();
    chk("late_finish", {63'd0, mmu_finish}, 64'd0);
    chk("late_preq", {63'd0, preq_valid}, 64'd0);
    chk("late_pa", pa, 64'd0);

    // Second mmu_valid mid-walk must not restart or retarget the walk.
    start(VA_WALK, SATP_SV39);
    start(64'h0, 64'd0);
    chk("restart_finish", {63'd0, mmu_finish}, 64'd0);
    serve("restart", 64'h8000_0008, 64'h2000_000F);
    wait_finish("restart");
    chk("restart_pa", pa, 64'h8000_1234);
    chk("restart_fault", {63'd0, page_fault}, 64'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
